memory_arbiter: RTL and testbench

- Sits directly downstream of the request block. Consumes its imemREN / dmemREN / dmemWEN strobes plus the datapath addresses and store data.
- Arbitrates them onto the single-ported RAM, which signals variable latency through ramstate.
- Returns one-cycle ihit/dhit pulses with load data. The request block uses these pulses to retire its requests.
- Data requests take priority over instruction fetch. A watchdog converts a hung or errored RAM access into a flagged completion so the CPU never deadlocks.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/arb_watchdog.sv | 43 ++++
 rtl/memory_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_memory_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types used by the memory arbiter and its watchdog.
//   word_t     : 32-bit machine word (addresses, load/store data)
//   ramstate_t : handshake state reported by the single-ported RAM
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog for the memory arbiter.
// Counts cycles spent inside a RAM access and flags when the access has
// lasted TIMEOUT cycles, so the arbiter can force a completion.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the count to zero (response cycle)
//   en         : count this cycle (an access cycle)
//   expired    : this access cycle is the TIMEOUT-th one
module arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the access cycles already completed, so the current
  // cycle is number count_q+1; it is the last allowed one at TIMEOUT-1.
  assign expired = en && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Memory arbiter: shares the single-ported RAM between instruction fetch and
// data load/store, data having priority. Returns one-cycle ihit/dhit pulses
// with load data and forces a flagged completion on RAM error or timeout.
//   CLK, nRST                    : clock, asynchronous active-low reset
//   imemREN, imemaddr            : instruction read request and address
//   dmemREN, dmemWEN, dmemaddr,
//   dmemstore                    : data read/write request, address, store data
//   ihit, imemload               : instruction completion pulse and word
//   dhit, dmemload               : data completion pulse and read word
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload, ramstate  : RAM-side interface
//   mem_error                    : sticky error flag, cleared only by reset
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT  = 255,
  parameter int    CNT_W    = 8,
  parameter word_t ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] imemload,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    DRSP = 3'd3,
    IRSP = 3'd4
  } arb_state_t;

  arb_state_t state_q, state_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic       wr_q, wr_d;
  word_t      imemload_q, imemload_d;
  word_t      dmemload_q, dmemload_d;
  logic       mem_error_q, mem_error_d;

  ramstate_t  ram_st;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  assign ram_st = ramstate_t'(ramstate);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (CLK),
    .rst_n   (nRST),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      store_q     <= '0;
      wr_q        <= 1'b0;
      imemload_q  <= '0;
      dmemload_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      wr_q        <= wr_d;
      imemload_q  <= imemload_d;
      dmemload_q  <= dmemload_d;
      mem_error_q <= mem_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    store_d     = store_q;
    wr_d        = wr_q;
    imemload_d  = imemload_q;
    dmemload_d  = dmemload_q;
    mem_error_d = mem_error_q;

    unique case (state_q)
      IDLE: begin
        // Data wins a simultaneous request; a read+write strobe pair is
        // resolved as a write and flagged.
        if (dmemWEN || dmemREN) begin
          addr_d  = dmemaddr;
          store_d = dmemstore;
          wr_d    = dmemWEN;
          if (dmemWEN && dmemREN) begin
            mem_error_d = 1'b1;
          end
          state_d = DACC;
        end else if (imemREN) begin
          addr_d  = imemaddr;
          wr_d    = 1'b0;
          state_d = IACC;
        end
      end

      DACC: begin
        // ACCESS is checked first so real data wins over a coincident timeout.
        if (ram_st == ACCESS) begin
          if (!wr_q) begin
            dmemload_d = ramload;
          end
          state_d = DRSP;
        end else if (ram_st == ERROR || wd_expired) begin
          if (!wr_q) begin
            dmemload_d = ERR_WORD;
          end
          mem_error_d = 1'b1;
          state_d     = DRSP;
        end
      end

      IACC: begin
        if (ram_st == ACCESS) begin
          imemload_d = ramload;
          state_d    = IRSP;
        end else if (ram_st == ERROR || wd_expired) begin
          imemload_d  = ERR_WORD;
          mem_error_d = 1'b1;
          state_d     = IRSP;
        end
      end

      // The bubble back through IDLE lets the requester drop its strobe.
      DRSP:    state_d = IDLE;
      IRSP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ihit   = 1'b0;
    dhit   = 1'b0;
    wd_en  = 1'b0;
    wd_clr = 1'b0;

    unique case (state_q)
      DACC: begin
        ramREN = !wr_q;
        ramWEN = wr_q;
        wd_en  = 1'b1;
      end
      IACC: begin
        ramREN = 1'b1;
        wd_en  = 1'b1;
      end
      DRSP: begin
        dhit   = 1'b1;
        wd_clr = 1'b1;
      end
      IRSP: begin
        ihit   = 1'b1;
        wd_clr = 1'b1;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  // The RAM only ever sees the captured request, never the live inputs.
  assign ramaddr   = addr_q;
  assign ramstore  = store_q;
  assign imemload  = imemload_q;
  assign dmemload  = dmemload_q;
  assign mem_error = mem_error_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a table of request vectors with
// expected final load/error state, a scoreboard of expected completions,
// and hand-written sequences for asynchronous reset mid-access.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRW = 32'hBAD1BAD1;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_error;

  memory_arbiter #(
    .TIMEOUT  (TO),
    .CNT_W    (8),
    .ERR_WORD (ERRW)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .ihit      (ihit),
    .dhit      (dhit),
    .imemload  (imemload),
    .dmemload  (dmemload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .mem_error (mem_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        i_ren;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dstore;
    int          busy;
    logic [1:0]  fin;
    logic [31:0] rload;
    logic [31:0] exp_iload;
    logic [31:0] exp_dload;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    int          cycles;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[9];
  vec_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt;
  int          last_hit;
  logic [31:0] m_iload;
  logic [31:0] m_dload;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input string name, input logic i_ren, input logic d_ren,
                              input logic d_wen, input logic [31:0] iaddr,
                              input logic [31:0] daddr, input logic [31:0] dstore,
                              input int busy, input logic [1:0] fin,
                              input logic [31:0] rload, input logic [31:0] exp_iload,
                              input logic [31:0] exp_dload, input logic exp_err);
    vec_t v;
    v.name = name; v.i_ren = i_ren; v.d_ren = d_ren; v.d_wen = d_wen;
    v.iaddr = iaddr; v.daddr = daddr; v.dstore = dstore; v.busy = busy;
    v.fin = fin; v.rload = rload; v.exp_iload = exp_iload;
    v.exp_dload = exp_dload; v.exp_err = exp_err;
    return v;
  endfunction

  // Reference behaviour of one access given the RAM's busy count and final state.
  task automatic model(input int busy, input logic [1:0] fin, input logic [31:0] rload,
                       output logic [31:0] ld, output int cyc, output logic bad);
    if (busy < TO && fin == 2'd2) begin
      ld = rload; cyc = busy + 1; bad = 1'b0;
    end else if (busy < TO && fin == 2'd3) begin
      ld = ERRW; cyc = busy + 1; bad = 1'b1;
    end else begin
      ld = ERRW; cyc = TO; bad = 1'b1;
    end
  endtask

  task automatic checkOutput(input int c);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_hit", {30'd0, ihit, dhit}, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({cur.name, "_hit_exclusive"}, {31'd0, ihit && dhit}, 32'd0);
    check({cur.name, "_hit_kind"}, {31'd0, dhit}, {31'd0, e.is_d});
    if (e.is_d) check({cur.name, "_dmemload"}, dmemload, e.load);
    else        check({cur.name, "_imemload"}, imemload, e.load);
    check({cur.name, "_mem_error"}, {31'd0, mem_error}, {31'd0, e.err});
    check({cur.name, "_access_cycles"}, acc_cnt, e.cycles);
    if (last_hit >= 0) check({cur.name, "_turnaround_ok"}, {31'd0, (c - last_hit) >= 3}, 32'd1);
    last_hit = c;
    acc_cnt  = 0;
    if (e.is_d) begin
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
    end else begin
      imemREN = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t        e;
    logic [31:0] ld;
    int          cyc;
    logic        bad;
    cur      = v;
    acc_cnt  = 0;
    last_hit = -1;
    @(negedge CLK);
    imemREN   = v.i_ren;
    imemaddr  = v.iaddr;
    dmemREN   = v.d_ren;
    dmemWEN   = v.d_wen;
    dmemaddr  = v.daddr;
    dmemstore = v.dstore;
    if (v.d_ren || v.d_wen) begin
      model(v.busy, v.fin, v.rload, ld, cyc, bad);
      e.is_d = 1'b1; e.wr = v.d_wen; e.addr = v.daddr; e.store = v.dstore; e.cycles = cyc;
      if (v.d_wen) begin
        bad = bad || v.d_ren;
        e.load = m_dload;
      end else begin
        e.load  = ld;
        m_dload = ld;
      end
      m_err = m_err || bad;
      e.err = m_err;
      sb.push_back(e);
    end
    if (v.i_ren) begin
      model(v.busy, v.fin, v.rload, ld, cyc, bad);
      e.is_d = 1'b0; e.wr = 1'b0; e.addr = v.iaddr; e.store = 32'd0;
      e.load = ld; e.cycles = cyc;
      m_iload = ld;
      m_err = m_err || bad;
      e.err = m_err;
      sb.push_back(e);
    end
    for (int c = 0; c < 80 && sb.size() > 0; c++) begin
      @(posedge CLK);
      #1;
      // Once captured, the live data inputs must have no effect.
      if (c == 0) begin
        if (v.d_ren || v.d_wen) begin
          dmemaddr  = $urandom;
          dmemstore = $urandom;
        end else begin
          imemaddr = $urandom;
        end
      end
      if (ramREN || ramWEN) begin
        acc_cnt++;
        check({v.name, "_ramaddr"}, ramaddr, sb[0].addr);
        check({v.name, "_ramWEN"}, {31'd0, ramWEN}, {31'd0, sb[0].wr});
        check({v.name, "_ramREN"}, {31'd0, ramREN}, {31'd0, !sb[0].wr});
        if (sb[0].wr) check({v.name, "_ramstore"}, ramstore, sb[0].store);
        ramstate = (acc_cnt <= v.busy) ? 2'd1 : v.fin;
        ramload  = (ramstate == 2'd2) ? v.rload : $urandom;
      end else begin
        ramstate = 2'd0;
        ramload  = $urandom;
      end
      if (ihit || dhit) checkOutput(c);
    end
    if (sb.size() != 0) begin
      check({v.name, "_completion_timeout"}, sb.size(), 0);
      sb.delete();
      imemREN = 1'b0;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
    end
    @(posedge CLK);
    #1;
    check({v.name, "_idle_after"}, {28'd0, ihit, dhit, ramREN, ramWEN}, 32'd0);
    check({v.name, "_final_imemload"}, imemload, v.exp_iload);
    check({v.name, "_final_dmemload"}, dmemload, v.exp_dload);
    check({v.name, "_final_mem_error"}, {31'd0, mem_error}, {31'd0, v.exp_err});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; dmemREN = 1'b0; dmemWEN = 1'b0;
    dmemaddr = '0; dmemstore = '0; ramload = '0; ramstate = 2'd0;
    m_iload = '0; m_dload = '0; m_err = 1'b0;

    //         name                 i  dR dW iaddr         daddr         dstore        busy fin    rload         exp_iload     exp_dload     err
    vecs[0] = mk("ifetch",          1, 0, 0, 32'h40,       32'h0,        32'h0,        2,   2'd2,  32'h8C220004, 32'h8C220004, 32'h00000000, 0);
    vecs[1] = mk("access_at_to",    0, 1, 0, 32'h0,        32'h80,       32'h0,        3,   2'd2,  32'h13579BDF, 32'h8C220004, 32'h13579BDF, 0);
    vecs[2] = mk("priority",        1, 1, 0, 32'h44,       32'h100,      32'h0,        1,   2'd2,  32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0);
    vecs[3] = mk("write",           0, 0, 1, 32'h0,        32'h200,      32'hDEADBEEF, 1,   2'd2,  32'h11112222, 32'hCAFEF00D, 32'hCAFEF00D, 0);
    vecs[4] = mk("read_fast",       0, 1, 0, 32'h0,        32'h204,      32'h0,        0,   2'd2,  32'h00001111, 32'hCAFEF00D, 32'h00001111, 0);
    vecs[5] = mk("timeout",         0, 1, 0, 32'h0,        32'h300,      32'h0,        10,  2'd1,  32'h00000000, 32'hCAFEF00D, 32'hBAD1BAD1, 1);
    vecs[6] = mk("sticky",          0, 1, 0, 32'h0,        32'h304,      32'h0,        0,   2'd2,  32'h55AA55AA, 32'hCAFEF00D, 32'h55AA55AA, 1);
    vecs[7] = mk("ram_error_i",     1, 0, 0, 32'h48,       32'h0,        32'h0,        0,   2'd3,  32'h99999999, 32'hBAD1BAD1, 32'h55AA55AA, 1);
    vecs[8] = mk("rw_conflict",     0, 1, 1, 32'h0,        32'h308,      32'h0BADF00D, 0,   2'd2,  32'h77777777, 32'hBAD1BAD1, 32'h55AA55AA, 1);

    // Reset state while nRST is held low.
    #12;
    check("reset_outputs", {26'd0, ihit, dhit, ramREN, ramWEN, mem_error, 1'b0}, 32'd0);
    check("reset_imemload", imemload, 32'd0);
    check("reset_dmemload", dmemload, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Asynchronous reset in the middle of a stalled data read.
    @(negedge CLK);
    dmemREN  = 1'b1;
    dmemaddr = 32'h400;
    @(posedge CLK);
    #1;
    check("rst_pre_ramREN", {31'd0, ramREN}, 32'd1);
    check("rst_pre_mem_error", {31'd0, mem_error}, 32'd1);
    ramstate = 2'd1;
    #2;
    nRST = 1'b0;
    #1;
    check("rst_async_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    check("rst_async_hits", {30'd0, ihit, dhit}, 32'd0);
    check("rst_async_mem_error", {31'd0, mem_error}, 32'd0);
    check("rst_async_dmemload", dmemload, 32'd0);
    check("rst_async_imemload", imemload, 32'd0);
    dmemREN  = 1'b0;
    ramstate = 2'd0;
    @(negedge CLK);
    nRST = 1'b1;
    m_iload = '0; m_dload = '0; m_err = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_release_idle", {30'd0, ramREN, ramWEN}, 32'd0);

    // A fresh fetch that needs the full watchdog window: a stale count
    // would force an early error.
    applyStimulus(mk("post_reset", 1, 0, 0, 32'h50, 32'h0, 32'h0, 3, 2'd2,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
